l2_cacheline_adaptor: RTL and testbench
=======================================

Name: l2_cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache, between its pmem_* line interface and the physical-memory burst port.
- Converts one 256-bit line read or write into a fixed sequence of four 64-bit bursts.
- Collects read bursts into a line and returns it to the L2 with a single-cycle response.
- Serialises write lines into bursts.

Parameters:
- LINE_WIDTH, 256, cache line width in bits (matches L2 s_line).
- BURST_WIDTH, 64, memory beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH = 4, beats per line (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- line_i  input  256  write line from L2 (pmem_wdata)
- line_o  output  256  assembled read line to L2 (pmem_rdata)
- address_i  input  32  line address from L2 (pmem_address)
- read_i  input  1  line read request from L2 (pmem_read)
- write_i  input  1  line write request from L2 (pmem_write)
- resp_o  output  1  line transaction complete to L2 (pmem_resp)
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  line-aligned address to memory
- read_o  output  1  burst read request to memory
- write_o  output  1  burst write request to memory
- resp_i  input  1  memory beat valid/accepted

Behaviour:
- All state updates on the rising edge of clk.
- rst is synchronous, active-high, and takes priority over everything else.
- rst effects:
  - state goes to IDLE.
  - beat counter goes to 0.
  - line buffer, line_o, burst_o and address_o go to 0.
  - read_o, write_o and resp_o go to 0.
  - An in-flight memory transaction is abandoned; no resp_o is issued for it.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If write_i=1: latch line_i into the buffer and {address_i[31:5],5'b0} into the address register, then go to WRITE.
  - Else if read_i=1: latch the address likewise, then go to READ.
  - If read_i and write_i are both high, write wins and the read is ignored.
  - Counter is cleared on entry to READ/WRITE.
- READ:
  - read_o=1 and address_o=latched aligned address.
  - Each cycle with resp_i=1: buffer[64*cnt +: 64] <= burst_i, and cnt increments.
  - Beat 0 is the lowest 64 bits. Cycles with resp_i=0 are gaps and do not advance cnt.
  - On the beat where cnt==3 and resp_i=1: go to DONE. read_o is low from the next cycle.
- WRITE:
  - write_o=1, address_o=latched address, burst_o=buffer[64*cnt +: 64] (combinational from cnt).
  - Each resp_i=1 means the beat was accepted; cnt increments.
  - On the beat where cnt==3 and resp_i=1: go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; line_o=buffer; then unconditionally return to IDLE.
  - The L2 deasserts its request on seeing resp_o, so no request is resampled in the DONE cycle.
- line_o reflects the buffer at all times. It is valid for the L2 on the resp_o cycle and holds until the next transaction overwrites the buffer.
- Latency:
  - Read: resp_o rises one cycle after the 4th resp_i beat.
  - Minimum read/write turnaround is 1 (IDLE) + 4 beats + 1 (DONE) = 6 cycles.
- Upstream rule: request, address_i and line_i are held stable until resp_o. The adaptor does not rely on this after latching.
- resp_i asserted in IDLE or DONE is ignored; no state or counter change.
- Counter is 2 bits and never wraps within a transaction.
- The address offset bits [4:0] of address_i are always forced to 0 on address_o.

Test Plan:
- Reset then idle: rst high 2 cycles, no requests -> all outputs 0, and resp_i pulses cause no state change.
- Read, contiguous beats:
  - Stimulus: read_i, address_i=0x0000_1234; burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high 4 cycles.
  - Response: address_o=0x0000_1220 and read_o high throughout; resp_o one cycle after beat 4; line_o = {0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with gaps: same as above but resp_i low 2 cycles between beats 1 and 2 -> identical line_o; resp_o delayed by 2 cycles; read_o held through the gaps.
- Write:
  - Stimulus: write_i, line_i=256'h0123_4567_89AB_CDEF_..., address_i=0x8000_007F.
  - Response: address_o=0x8000_0060; burst_o steps through bits [63:0],[127:64],[191:128],[255:192] on each accepted beat; write_o drops and resp_o pulses once after beat 4.
- Simultaneous read_i and write_i in IDLE -> write_o asserted, read_o never asserted, one resp_o.
- Reset mid-read: rst after beat 2 -> read_o=0 next cycle, resp_o never pulses; a new read afterwards starts at beat 0 and completes normally.

Source files
------------

// File: rtl/l2_cacheline_adaptor_if.sv
// l2_cacheline_adaptor_if
//   Bundles the L2-side line port and the memory-side burst port of the
//   cache-line adaptor. Signal suffixes are named from the adaptor's view.
//   L2 side    : line_i, line_o, address_i, read_i, write_i, resp_o
//   Memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   slave  modport - the adaptor itself
//   master modport - the environment (L2 plus memory) driving the adaptor
interface l2_cacheline_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) ();
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [31:0]            address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//   Converts one L2 line read/write into a fixed sequence of memory bursts
//   (four 64-bit beats for a 256-bit line). Read beats are assembled into
//   the line buffer, lowest beat first; write lines are serialised from it.
//   The L2 sees a single-cycle resp_o once the last beat has been taken.
//   Ports:
//     clk - system clock
//     rst - synchronous active-high reset
//     bus - l2_cacheline_adaptor_if.slave (L2 line port + memory burst port)
//
//   state | meaning
//   IDLE  | waiting for an L2 request; requests are sampled only here
//   READ  | read_o high, collecting beats into the line buffer
//   WRITE | write_o high, presenting buffer beats until each is accepted
//   DONE  | one-cycle resp_o to the L2, then back to IDLE
module l2_cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_cacheline_adaptor_if.slave bus
);
    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFFS_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [LINE_WIDTH-1:0]  buf_q,   buf_d;
    logic [31:0]            addr_q,  addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Write has priority when both requests are raised together.
                if (bus.write_i) begin
                    buf_d   = bus.line_i;
                    addr_d  = bus.address_i & ADDR_MASK;
                    state_d = WRITE;
                end else if (bus.read_i) begin
                    addr_d  = bus.address_i & ADDR_MASK;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    buf_d[BURST_WIDTH*cnt_q +: BURST_WIDTH] = bus.burst_i;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                    else                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                    else                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.read_o    = (state_q == READ);
        bus.write_o   = (state_q == WRITE);
        bus.resp_o    = (state_q == DONE);
        bus.address_o = addr_q;
        bus.line_o    = buf_q;
        bus.burst_o   = buf_q[BURST_WIDTH*cnt_q +: BURST_WIDTH];
    end
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor
//   Random and directed line reads/writes against the cache-line adaptor.
//   A stimulus process issues L2 requests and queues the expected line;
//   a memory responder supplies/accepts beats with random gaps; a monitor
//   pops the queue whenever resp_o is presented and compares.
module tb_l2_cacheline_adaptor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_cacheline_adaptor_if bus ();

    l2_cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] rd_beats_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Shared model state: written by stimulus, read by responder/monitor.
    bit          txn_live = 1'b0;
    bit          txn_wr   = 1'b0;
    logic [31:0] txn_addr = '0;
    int          gap_pct  = 0;
    int          stall_after_first = 0;
    bit          idle_pulse_en = 1'b0;

    // Responder-owned state.
    int           beats_done    = 0;
    int           stall_cnt     = 0;
    int           last_beat_cyc = -100;
    logic [255:0] wr_cap        = '0;

    bit prev_resp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory side: beat supply/acceptance plus per-cycle control checks.
    always @(negedge clk) begin
        if (rst) begin
            bus.resp_i = 1'b0;
            beats_done = 0;
            stall_cnt  = 0;
            rd_beats_q.delete();
        end else begin
            chk("read_o",  {255'd0, bus.read_o},  {255'd0, txn_live && !txn_wr && beats_done < 4});
            chk("write_o", {255'd0, bus.write_o}, {255'd0, txn_live &&  txn_wr && beats_done < 4});
            if (bus.read_o || bus.write_o)
                chk("address_o", {224'd0, bus.address_o}, {224'd0, txn_addr});
            if (txn_live && beats_done < 4) begin
                if (stall_cnt > 0) begin
                    stall_cnt--;
                    bus.resp_i = 1'b0;
                end else if ($urandom_range(99) < gap_pct) begin
                    bus.resp_i = 1'b0;
                end else begin
                    bus.resp_i = 1'b1;
                    if (txn_wr) begin
                        wr_cap[64*beats_done +: 64] = bus.burst_o;
                    end else if (rd_beats_q.size() == 0) begin
                        chk("beat_supply", 256'd0, 256'd1);
                    end else begin
                        bus.burst_i = rd_beats_q.pop_front();
                    end
                    beats_done++;
                    if (beats_done == 1) stall_cnt = stall_after_first;
                    if (beats_done == 4) last_beat_cyc = cyc;
                end
            end else begin
                if (!txn_live) begin
                    beats_done = 0;
                    stall_cnt  = 0;
                end
                bus.resp_i  = idle_pulse_en ? 1'($urandom_range(1)) : 1'b0;
                bus.burst_i = {$urandom, $urandom};
            end
        end
    end

    // Monitor: compare on every resp_o presented by the adaptor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.resp_o) begin
                if (prev_resp) chk("resp_o_width", 256'd1, 256'd0);
                if (sb_q.size() == 0) begin
                    chk("resp_o_spurious", 256'd1, 256'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_wr) chk("write_line", wr_cap, e.line);
                    else         chk("read_line", bus.line_o, e.line);
                    chk("resp_latency", 256'(cyc), 256'(last_beat_cyc + 1));
                end
            end
            prev_resp = bus.resp_o;
        end else begin
            prev_resp = 1'b0;
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_line_o"},    bus.line_o, 256'd0);
        chk({tag, "_burst_o"},   {192'd0, bus.burst_o}, 256'd0);
        chk({tag, "_address_o"}, {224'd0, bus.address_o}, 256'd0);
        chk({tag, "_ctrl"},      {253'd0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        txn_live    = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request at posedge+1 and holds it until resp_o is seen.
    // For reads, l is the line memory will return (beat 0 = l[63:0]).
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [255:0] l, input int gp, input int stall_f);
        exp_t e;
        bit   seen;
        gap_pct           = gp;
        stall_after_first = stall_f;
        e.is_wr = wr;
        e.addr  = a & 32'hFFFF_FFE0;
        e.line  = l;
        if (!wr) for (int i = 0; i < 4; i++) rd_beats_q.push_back(l[64*i +: 64]);
        sb_q.push_back(e);
        txn_wr      = wr;
        txn_addr    = e.addr;
        bus.read_i  = rd;
        bus.write_i = wr;
        bus.address_i = a;
        bus.line_i  = wr ? l : {8{$urandom}};
        @(posedge clk);
        #1 txn_live = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (bus.resp_o) seen = 1'b1;
        end
        if (!seen) begin
            chk("resp_timeout", 256'd0, 256'd1);
            pulse_reset();
        end else begin
            @(posedge clk);
            #1;
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
            txn_live    = 1'b0;
            bus.address_i = $urandom;
            bus.line_i  = {8{$urandom}};
        end
    endtask

    initial begin
        logic [255:0] rd_line;
        logic [255:0] wr_line;
        logic [255:0] rnd_line;
        bit           ok;
        rd_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        wr_line = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

        rst = 1'b1;
        bus.read_i = 1'b0;
        bus.write_i = 1'b0;
        bus.address_i = '0;
        bus.line_i = '0;
        bus.resp_i = 1'b0;
        bus.burst_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        // resp_i pulses while idle must be ignored.
        idle_pulse_en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_quiet("idle_pulse");
        end
        @(posedge clk);
        #1 idle_pulse_en = 1'b0;

        do_txn(1'b1, 1'b0, 32'h0000_1234, rd_line, 0, 0);
        do_txn(1'b1, 1'b0, 32'h0000_1234, rd_line, 0, 2);
        do_txn(1'b0, 1'b1, 32'h8000_007F, wr_line, 0, 0);
        do_txn(1'b1, 1'b1, 32'h4000_0005, wr_line ^ rd_line, 0, 0);

        // Reset after the second read beat abandons the transaction.
        gap_pct = 0;
        stall_after_first = 0;
        for (int i = 0; i < 4; i++) rd_beats_q.push_back({$urandom, $urandom});
        txn_wr = 1'b0;
        txn_addr = 32'h0000_2200;
        bus.read_i = 1'b1;
        bus.address_i = 32'h0000_2217;
        @(posedge clk);
        #1 txn_live = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (beats_done >= 2) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("mid_read_beats", {255'd0, ok}, 256'd1);
        rst = 1'b1;
        bus.read_i = 1'b0;
        txn_live = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_quiet("mid_read_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 32'h0000_1234, rd_line, 0, 0);

        idle_pulse_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int k;
            k = $urandom_range(2);
            rnd_line = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
            do_txn(k != 1, k != 0, $urandom, rnd_line,
                   $urandom_range(60), $urandom_range(3));
        end
        idle_pulse_en = 1'b0;
        repeat (4) @(posedge clk);
        chk("sb_drained", 256'(sb_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
